// File: rtl/uart_cmd_pkg.sv
// Shared types and protocol byte values for the UART command responder.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXEC,
        SEND,
        WAIT_DONE
    } cmd_state_t;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

endpackage

// File: rtl/uart_cmd_responder.sv
// Parses 2/3-byte read/write frames from the UART receiver against a local
// register file and returns one response byte through the transmit handshake.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int DATA_LEN     = 8,
    parameter int NUM_REGS     = 16,
    parameter int TIMEOUT_CLKS = 26040
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         receive_signal,
    input  logic [DATA_LEN-1:0]          data_in,
    input  logic                         tx_busy,
    input  logic                         tx_done,
    output logic                         send_signal,
    output logic [DATA_LEN-1:0]          data_out,
    output logic [NUM_REGS*DATA_LEN-1:0] regs_out,
    output logic                         frame_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [DATA_LEN:0] REG_LIMIT = (DATA_LEN + 1)'(NUM_REGS);

    cmd_state_t          state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                is_write, is_write_nxt;
    logic [DATA_LEN-1:0] addr, addr_nxt;
    logic [DATA_LEN-1:0] wdata, wdata_nxt;
    logic [DATA_LEN-1:0] data_out_nxt;
    logic                send_nxt;
    logic                ferr_nxt;
    logic                reg_we;
    logic                addr_ok;
    logic [IDX_W-1:0]    idx;
    logic [DATA_LEN-1:0] regs [NUM_REGS];

    // Range check uses the whole address byte, so aliases above NUM_REGS are rejected.
    assign addr_ok = ({1'b0, addr} < REG_LIMIT);
    assign idx     = addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            is_write    <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            data_out    <= '0;
            send_signal <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            is_write    <= is_write_nxt;
            addr        <= addr_nxt;
            wdata       <= wdata_nxt;
            data_out    <= data_out_nxt;
            send_signal <= send_nxt;
            frame_error <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        is_write_nxt = is_write;
        addr_nxt     = addr;
        wdata_nxt    = wdata;
        data_out_nxt = data_out;
        send_nxt     = 1'b0;
        ferr_nxt     = 1'b0;
        reg_we       = 1'b0;
        case (state)
            IDLE: begin
                if (receive_signal) begin
                    if (data_in == DATA_LEN'(CMD_READ) || data_in == DATA_LEN'(CMD_WRITE)) begin
                        is_write_nxt = (data_in == DATA_LEN'(CMD_WRITE));
                        cnt_nxt      = '0;
                        state_nxt    = GET_ADDR;
                    end else begin
                        data_out_nxt = DATA_LEN'(RSP_NAK);
                        send_nxt     = !tx_busy;
                        state_nxt    = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (receive_signal) begin
                    addr_nxt  = data_in;
                    cnt_nxt   = '0;
                    state_nxt = is_write ? GET_DATA : EXEC;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    ferr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GET_DATA: begin
                if (receive_signal) begin
                    wdata_nxt = data_in;
                    cnt_nxt   = '0;
                    state_nxt = EXEC;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    ferr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            EXEC: begin
                ferr_nxt = receive_signal;
                if (!addr_ok) begin
                    data_out_nxt = DATA_LEN'(RSP_NAK);
                end else if (is_write) begin
                    reg_we       = 1'b1;
                    data_out_nxt = DATA_LEN'(RSP_ACK);
                end else begin
                    data_out_nxt = regs[idx];
                end
                send_nxt  = !tx_busy;
                state_nxt = SEND;
            end
            SEND: begin
                // The request pulse is registered, so leave once it has been driven.
                ferr_nxt = receive_signal;
                if (send_signal) begin
                    state_nxt = WAIT_DONE;
                end else begin
                    send_nxt = !tx_busy;
                end
            end
            WAIT_DONE: begin
                ferr_nxt = receive_signal;
                if (tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[idx] <= wdata;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[g*DATA_LEN +: DATA_LEN] = regs[g];
    end

endmodule
